// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer of the accumulator CPU:
// opcode encodings, control-word bit positions, FSM state encoding and a
// helper mapping an opcode to the ALU operation bit it drives.
package cpu_ctrl_pkg;

  // Opcode encodings (0x0C..0x1F are illegal)
  localparam int unsigned OP_NOP  = 32'h00;
  localparam int unsigned OP_ADD  = 32'h01;
  localparam int unsigned OP_SUB  = 32'h02;
  localparam int unsigned OP_AND  = 32'h03;
  localparam int unsigned OP_OR   = 32'h04;
  localparam int unsigned OP_NOT  = 32'h05;
  localparam int unsigned OP_SHL  = 32'h06;
  localparam int unsigned OP_SHR  = 32'h07;
  localparam int unsigned OP_ASHL = 32'h08;
  localparam int unsigned OP_ASHR = 32'h09;
  localparam int unsigned OP_MPY  = 32'h0A;
  localparam int unsigned OP_CLR  = 32'h0B;

  // Control word bit positions
  localparam int CB_ACC_LD = 10;
  localparam int CB_MR_LD  = 11;
  localparam int CB_BR_LD  = 12;
  localparam int CB_CLR    = 21;
  localparam int CB_ADD    = 22;
  localparam int CB_SUB    = 23;
  localparam int CB_AND    = 24;
  localparam int CB_OR     = 25;
  localparam int CB_NOT    = 26;
  localparam int CB_SHL    = 27;
  localparam int CB_SHR    = 28;
  localparam int CB_MPY    = 29;
  localparam int CB_ASHL   = 30;
  localparam int CB_ASHR   = 31;

  localparam int CS_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // ALU bit index driven during EXEC; 0 means "no ALU operation"
  // (bit 0 is never an ALU bit, so it doubles as the NOP/illegal marker).
  function automatic logic [4:0] alu_bit_of(input int unsigned op);
    case (op)
      OP_ADD:  alu_bit_of = 5'(CB_ADD);
      OP_SUB:  alu_bit_of = 5'(CB_SUB);
      OP_AND:  alu_bit_of = 5'(CB_AND);
      OP_OR:   alu_bit_of = 5'(CB_OR);
      OP_NOT:  alu_bit_of = 5'(CB_NOT);
      OP_SHL:  alu_bit_of = 5'(CB_SHL);
      OP_SHR:  alu_bit_of = 5'(CB_SHR);
      OP_ASHL: alu_bit_of = 5'(CB_ASHL);
      OP_ASHR: alu_bit_of = 5'(CB_ASHR);
      OP_MPY:  alu_bit_of = 5'(CB_MPY);
      OP_CLR:  alu_bit_of = 5'(CB_CLR);
      default: alu_bit_of = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
//   opcode   in   OP_W  ALU opcode
//   alu_bit  out  5     control-word bit of the ALU op (0 = none)
//   needs_br out  1     two-operand op: BR must be loaded first
//   is_shift out  1     single-bit shift repeated shamt times
//   is_mpy   out  1     multiply: writeback also loads MR
//   illegal  out  1     unknown opcode
module alu_op_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output logic [4:0]      alu_bit,
  output logic            needs_br,
  output logic            is_shift,
  output logic            is_mpy,
  output logic            illegal
);

  int unsigned op_ext;

  always_comb begin
    op_ext   = 32'(opcode);
    alu_bit  = alu_bit_of(op_ext);
    needs_br = (op_ext == OP_ADD) || (op_ext == OP_SUB) || (op_ext == OP_AND) ||
               (op_ext == OP_OR)  || (op_ext == OP_MPY);
    is_shift = (op_ext == OP_SHL) || (op_ext == OP_SHR) ||
               (op_ext == OP_ASHL) || (op_ext == OP_ASHR);
    is_mpy   = (op_ext == OP_MPY);
    illegal  = (op_ext > OP_CLR);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller. Accepts one instruction via valid/ready and
// steps IDLE -> [LOAD] -> EXEC -> WB (-> EXEC ... for shifts) -> DONE,
// driving a registered 32-bit control word to the ALU/ACC/BR/MR slice.
//   clk, rst        clock, async active-high reset
//   instr_valid/_ready  handshake; accept when both high at a rising edge
//   opcode, shamt   instruction fields, latched at accept
//   flush           synchronous abort back to IDLE (no done)
//   control_signal  registered control word
//   done, illegal   one-cycle completion pulse / unknown-opcode flag
module alu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int OP_W        = 5,
  parameter int SHAMT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic [31:0]        control_signal,
  output logic               done,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [SHAMT_W-1:0] rep_q, rep_d;
  logic [2:0]         cyc_q, cyc_d;
  logic               ill_q, ill_d;
  logic [31:0]        cs_q, cs_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;

  // Decode the live opcode while idle (to pick the first state) and the
  // latched one afterwards; one decoder serves both.
  logic [OP_W-1:0] dec_op;
  logic [4:0]      dec_bit;
  logic            dec_br, dec_shift, dec_mpy, dec_ill;

  assign dec_op = (state_q == S_IDLE) ? opcode : op_q;

  alu_op_decode #(.OP_W(OP_W)) u_dec (
    .opcode   (dec_op),
    .alu_bit  (dec_bit),
    .needs_br (dec_br),
    .is_shift (dec_shift),
    .is_mpy   (dec_mpy),
    .illegal  (dec_ill)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rep_q     <= '0;
      cyc_q     <= '0;
      ill_q     <= 1'b0;
      cs_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rep_q     <= rep_d;
      cyc_q     <= cyc_d;
      ill_q     <= ill_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rep_d   = rep_q;
    cyc_d   = cyc_q;
    ill_d   = ill_q;
    if (flush) begin
      // Flush wins over everything, including an accept in IDLE.
      state_d = S_IDLE;
      rep_d   = '0;
      cyc_d   = '0;
      ill_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_d  = opcode;
            rep_d = shamt;
            cyc_d = '0;
            ill_d = dec_ill;
            if (dec_ill || (dec_bit == 5'd0) || (dec_shift && (shamt == '0)))
              state_d = S_DONE;
            else if (dec_br)
              state_d = S_LOAD;
            else
              state_d = S_EXEC;
          end
        end
        S_LOAD: begin
          state_d = S_EXEC;
          cyc_d   = '0;
        end
        S_EXEC: begin
          if (cyc_q == 3'(EXEC_CYCLES - 1)) begin
            state_d = S_WB;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 3'd1;
          end
        end
        S_WB: begin
          if (dec_shift) begin
            // rep_cnt counts remaining passes including this one; it
            // saturates at zero rather than wrapping.
            if (rep_q != '0) rep_d = rep_q - SHAMT_W'(1);
            state_d = (rep_q > SHAMT_W'(1)) ? S_EXEC : S_DONE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          ill_d   = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: the control word is registered from the *next* state so
  // it lines up with the state it belongs to.
  always_comb begin
    cs_d      = '0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_d)
      S_LOAD: cs_d[CB_BR_LD] = 1'b1;
      S_EXEC: cs_d[dec_bit]  = 1'b1;
      S_WB: begin
        cs_d[CB_ACC_LD] = 1'b1;
        cs_d[CB_MR_LD]  = dec_mpy;
      end
      S_DONE: begin
        done_d    = 1'b1;
        illegal_d = ill_d;
      end
      default: ;
    endcase
  end

  assign instr_ready    = (state_q == S_IDLE);
  assign control_signal = cs_q;
  // A flush seen during the DONE cycle itself must still cancel the pulse,
  // so the registered pulse is masked by the live flush.
  assign done           = done_q & ~flush;
  assign illegal        = illegal_q & ~flush;

endmodule
